// File: rtl/btn_event_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, per-bit debounce, and registered
// press/release event pulses with optional typematic auto-repeat on held buttons.
module btn_event_debounce #(
    parameter int NBTN         = 8,
    parameter int DEBOUNCE     = 500000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic            i_clk,
    input  logic            i_areset_n,
    input  logic [NBTN-1:0] i_btn,
    input  logic            i_repeat_en,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic            o_any
);

    localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [NBTN-1:0] sync1_reg;
    logic [NBTN-1:0] sync2_reg;
    logic [NBTN-1:0] btn_reg;
    logic [NBTN-1:0] press_reg;
    logic [NBTN-1:0] release_reg;
    logic            any_reg;

    logic [NBTN-1:0] btn_next;
    logic [NBTN-1:0] press_next;
    logic [NBTN-1:0] release_next;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            btn_reg     <= '0;
            press_reg   <= '0;
            release_reg <= '0;
            any_reg     <= 1'b0;
        end else begin
            sync1_reg   <= i_btn;
            sync2_reg   <= sync1_reg;
            btn_reg     <= btn_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            any_reg     <= |press_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic [DB_W-1:0]  db_cnt_reg;
            logic [DB_W-1:0]  db_cnt_next;
            logic             level_next;
            logic             press_acc;
            logic             rel_acc;
            logic             rpt_pulse;
            rpt_state_t       state_reg;
            rpt_state_t       state_next;
            logic [RPT_W-1:0] rpt_cnt_reg;
            logic [RPT_W-1:0] rpt_cnt_next;

            always_ff @(posedge i_clk or negedge i_areset_n) begin
                if (!i_areset_n) begin
                    db_cnt_reg  <= '0;
                    state_reg   <= RPT_IDLE;
                    rpt_cnt_reg <= '0;
                end else begin
                    db_cnt_reg  <= db_cnt_next;
                    state_reg   <= state_next;
                    rpt_cnt_reg <= rpt_cnt_next;
                end
            end

            // Counter only advances while the synchronised pin disagrees with the
            // accepted level; it tops out at DEBOUNCE-1, so it can never wrap.
            always_comb begin
                db_cnt_next = '0;
                level_next  = btn_reg[gi];
                if (sync2_reg[gi] != btn_reg[gi]) begin
                    if (db_cnt_reg == DB_LAST) begin
                        level_next = ~btn_reg[gi];
                    end else begin
                        db_cnt_next = db_cnt_reg + 1'b1;
                    end
                end
                press_acc = level_next & ~btn_reg[gi];
                rel_acc   = ~level_next & btn_reg[gi];
            end

            // Release and disable both dominate, which also makes release win over
            // a repeat pulse due on the same edge.
            always_comb begin
                state_next   = state_reg;
                rpt_cnt_next = rpt_cnt_reg;
                rpt_pulse    = 1'b0;
                if (!i_repeat_en || rel_acc) begin
                    state_next   = RPT_IDLE;
                    rpt_cnt_next = '0;
                end else begin
                    case (state_reg)
                        RPT_IDLE: begin
                            rpt_cnt_next = '0;
                            if (press_acc) begin
                                state_next = RPT_DELAY;
                            end
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt_reg == DLY_LAST) begin
                                rpt_pulse    = 1'b1;
                                state_next   = RPT_REPEAT;
                                rpt_cnt_next = '0;
                            end else begin
                                rpt_cnt_next = rpt_cnt_reg + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (rpt_cnt_reg == RATE_LAST) begin
                                rpt_pulse    = 1'b1;
                                rpt_cnt_next = '0;
                            end else begin
                                rpt_cnt_next = rpt_cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_next   = RPT_IDLE;
                            rpt_cnt_next = '0;
                        end
                    endcase
                end
            end

            assign btn_next[gi]     = level_next;
            assign press_next[gi]   = press_acc | rpt_pulse;
            assign release_next[gi] = rel_acc;
        end
    endgenerate

    assign o_btn     = btn_reg;
    assign o_press   = press_reg;
    assign o_release = release_reg;
    assign o_any     = any_reg;

endmodule

// File: tb/tb_btn_event_debounce.sv
// Directed bench for btn_event_debounce with short debounce/repeat timings so
// every expected edge can be counted by hand.
module tb_btn_event_debounce;

    logic       clk;
    logic       rst_n;
    logic [7:0] btn;
    logic       rpt_en;
    logic [7:0] o_btn;
    logic [7:0] o_press;
    logic [7:0] o_release;
    logic       o_any;

    int tests;
    int errors;
    logic [7:0] acc_p;
    logic [7:0] acc_r;
    logic [7:0] acc_b;

    btn_event_debounce #(
        .NBTN(8), .DEBOUNCE(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .i_clk(clk), .i_areset_n(rst_n), .i_btn(btn), .i_repeat_en(rpt_en),
        .o_btn(o_btn), .o_press(o_press), .o_release(o_release), .o_any(o_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns 1 ns after a rising edge, so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("[TB] %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        rst_n  = 1'b0;
        btn    = 8'hFF;
        rpt_en = 1'b0;

        // Reset with every button held; fresh press accepted on the 6th edge after release.
        tick(); tick();
        check("rst_btn", o_btn, 8'h00);
        check("rst_press", o_press, 8'h00);
        check("rst_release", o_release, 8'h00);
        check("rst_any", {7'd0, o_any}, 8'h00);
        #4 rst_n = 1'b1;
        acc_b = 8'h00; acc_p = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            acc_b |= o_btn; acc_p |= o_press;
        end
        check("hold_btn_pre", acc_b, 8'h00);
        check("hold_press_pre", acc_p, 8'h00);
        tick();
        check("hold_btn_e6", o_btn, 8'hFF);
        check("hold_press_e6", o_press, 8'hFF);
        check("hold_any_e6", {7'd0, o_any}, 8'h01);
        tick();
        check("hold_press_e7", o_press, 8'h00);
        check("hold_any_e7", {7'd0, o_any}, 8'h00);

        // Clean release of button 0.
        btn = 8'hFE;
        acc_r = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            acc_r |= o_release;
        end
        check("rel0_pre", acc_r, 8'h00);
        tick();
        check("rel0_e6", o_release, 8'h01);
        check("rel0_btn", o_btn, 8'hFE);

        // Bounce on button 0: 2-cycle toggles never reach 4 stable samples.
        acc_p = 8'h00; acc_b = 8'hFE;
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            tick(); acc_p |= o_press; acc_b &= o_btn;
            tick(); acc_p |= o_press; acc_b &= o_btn;
        end
        check("bounce_press", acc_p, 8'h00);
        check("bounce_btn", acc_b, 8'hFE);
        btn[0] = 1'b1;
        acc_p = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            acc_p |= o_press;
        end
        check("bounce_press_pre", acc_p, 8'h00);
        tick();
        check("bounce_press_e6", o_press, 8'h01);
        check("bounce_btn_e6", o_btn, 8'hFF);
        tick();
        check("bounce_press_e7", o_press, 8'h00);

        // Release of button 2 with a 3-cycle glitch back to pressed.
        acc_p = 8'h00; acc_r = 8'h00;
        btn[2] = 1'b0;
        tick(); acc_p |= o_press; acc_r |= o_release;
        tick(); acc_p |= o_press; acc_r |= o_release;
        btn[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); acc_p |= o_press; acc_r |= o_release;
        end
        btn[2] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(); acc_p |= o_press; acc_r |= o_release;
        end
        check("glitch_release_pre", acc_r, 8'h00);
        tick(); acc_p |= o_press;
        check("glitch_release_e6", o_release, 8'h04);
        check("glitch_btn_e6", o_btn, 8'hFB);
        check("glitch_press", acc_p, 8'h00);
        btn[2] = 1'b1;
        repeat (8) tick();
        check("btn2_restored", o_btn, 8'hFF);

        // Auto-repeat on button 3.
        btn[3] = 1'b0;
        repeat (8) tick();
        check("btn3_released", o_btn, 8'hF7);
        rpt_en = 1'b1;
        btn[3] = 1'b1;
        repeat (6) tick();
        check("rpt_T", o_press, 8'h08);
        acc_p = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            tick(); acc_p |= o_press;
        end
        check("rpt_delay_quiet", acc_p, 8'h00);
        tick(); check("rpt_T10", o_press, 8'h08);
        acc_p = 8'h00;
        tick(); acc_p |= o_press; tick(); acc_p |= o_press;
        tick(); check("rpt_T13", o_press, 8'h08);
        tick(); acc_p |= o_press; tick(); acc_p |= o_press;
        tick(); check("rpt_T16", o_press, 8'h08);
        check("rpt_gap_quiet", acc_p, 8'h00);
        check("rpt_any_T16", {7'd0, o_any}, 8'h01);
        rpt_en = 1'b0;
        acc_p = 8'h00;
        tick(); acc_p |= o_press; tick(); acc_p |= o_press;
        tick(); check("rpt_off_T19", o_press, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick(); acc_p |= o_press;
        end
        check("rpt_off_quiet", acc_p, 8'h00);

        // Re-enabling while held does not restart repeats.
        rpt_en = 1'b1;
        acc_p = 8'h00;
        for (int i = 0; i < 14; i++) begin
            tick(); acc_p |= o_press;
        end
        check("reenable_quiet", acc_p, 8'h00);

        // Release accepted on the edge a repeat pulse is due.
        btn[3] = 1'b0;
        repeat (8) tick();
        btn[3] = 1'b1;
        repeat (6) tick();
        check("coll_T", o_press, 8'h08);
        repeat (7) tick();
        btn[3] = 1'b0;
        tick(); tick();
        tick(); check("coll_T10", o_press, 8'h08);
        acc_p = 8'h00;
        tick(); acc_p |= o_press; tick(); acc_p |= o_press;
        tick();
        check("coll_T13_release", o_release, 8'h08);
        check("coll_T13_press", o_press, 8'h00);
        check("coll_T13_btn", o_btn, 8'hF7);
        for (int i = 0; i < 8; i++) begin
            tick(); acc_p |= o_press;
        end
        check("coll_after_quiet", acc_p, 8'h00);

        // Asynchronous reset while o_btn = 0F, buttons still held.
        rpt_en = 1'b0;
        btn = 8'h0F;
        repeat (8) tick();
        check("mid_btn", o_btn, 8'h0F);
        #2 rst_n = 1'b0;
        #1;
        check("arst_btn", o_btn, 8'h00);
        check("arst_press", o_press, 8'h00);
        check("arst_release", o_release, 8'h00);
        check("arst_any", {7'd0, o_any}, 8'h00);
        tick(); tick();
        #4 rst_n = 1'b1;
        acc_b = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            tick(); acc_b |= o_btn;
        end
        check("arst_btn_pre", acc_b, 8'h00);
        tick();
        check("arst_btn_e6", o_btn, 8'h0F);
        check("arst_press_e6", o_press, 8'h0F);
        check("arst_any_e6", {7'd0, o_any}, 8'h01);
        tick();
        check("arst_press_e7", o_press, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
